// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding one UART transmitter.
// With LOCK_EN set, a grant is held across a multi-byte packet until its last
// byte. A bounded HOLD timeout releases a lock whose owner stops sending.
module uart_tx_arbiter #(
    parameter int unsigned HOLD_TIMEOUT = 1000000,
    parameter int unsigned LOCK_EN      = 1
) (
    input  logic        i_SysClock,
    input  logic        i_ResetN,
    input  logic [3:0]  i_ReqValid,
    input  logic [31:0] i_ReqData,
    input  logic [3:0]  i_ReqLast,
    output logic [3:0]  o_ReqReady,
    output logic        o_TxValid,
    output logic [7:0]  o_TxByte,
    input  logic        i_TxDone,
    output logic [1:0]  o_GrantId,
    output logic        o_Busy,
    output logic        o_Timeout
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
    logic               last_q, last_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic [N_REQ-1:0]   ready_c;

    logic               rr_found;
    logic [ID_W-1:0]    rr_win;

    // Round-robin search starting one past the last grant and wrapping to it.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand     = '0;
        rr_found = 1'b0;
        rr_win   = grant_q;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = ID_W'(grant_q + ID_W'(i));
            if (!rr_found && i_ReqValid[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    // Next-state, accept strobe and launch-register updates.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        last_d     = last_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        ready_c    = '0;

        case (state_q)
            ST_IDLE: begin
                // Ready is gated by reset so nothing is accepted while held in reset.
                if (i_ResetN && i_TxDone && rr_found) begin
                    ready_c[rr_win] = 1'b1;
                    tx_byte_d       = i_ReqData[{rr_win, 3'b000} +: BYTE_W];
                    last_d          = i_ReqLast[rr_win];
                    grant_d         = rr_win;
                    tx_valid_d      = 1'b1;
                    state_d         = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Transmitter has taken the byte once it reports not idle.
                if (!i_TxDone) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_TxDone) begin
                    if ((LOCK_EN != 0) && !last_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // Acceptance outranks expiry in the same cycle.
                if (i_ReqValid[grant_q]) begin
                    ready_c[grant_q] = 1'b1;
                    tx_byte_d        = i_ReqData[{grant_q, 3'b000} +: BYTE_W];
                    last_d           = i_ReqLast[grant_q];
                    tx_valid_d       = 1'b1;
                    state_d          = ST_LAUNCH;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
            last_q     <= 1'b0;
            grant_q    <= ID_W'(N_REQ - 1);
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_ReqReady = ready_c;
    assign o_TxValid  = tx_valid_q;
    assign o_TxByte   = tx_byte_q;
    assign o_GrantId  = grant_q;
    assign o_Busy     = (state_q != ST_IDLE);
    assign o_Timeout  = timeout_q;

endmodule
